uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a uart_tx: queues pushed bytes and launches them one at a
// time, waiting for the transmitter's Active/Done handshake to finish between launches.
module uart_tx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Wr_En,
    input  logic [7:0]        i_Wr_Data,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Busy,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    localparam int              DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACTIVE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop;
    logic              push;
    logic [ADDR_W:0]   count_next;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        count_next = o_Count;
        pop        = (state == IDLE) && !o_Empty && !i_Tx_Active && !i_Tx_Done;
        push       = i_Wr_En && (!o_Full || pop);
        if (push && !pop) begin
            count_next = o_Count + 1'b1;
        end else if (pop && !push) begin
            count_next = o_Count - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Empty    <= 1'b1;
            o_Full     <= 1'b0;
            o_Overflow <= 1'b0;
            o_Busy     <= 1'b0;
            o_Tx_DV    <= 1'b0;
            o_Tx_Byte  <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            o_Count    <= count_next;
            o_Empty    <= (count_next == '0);
            o_Full     <= (count_next == FULL_COUNT);
            o_Overflow <= i_Wr_En && !push;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            o_Tx_DV <= 1'b0;
            o_Busy  <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= LAUNCH;
                        o_Tx_DV   <= 1'b1;
                        o_Tx_Byte <= mem[rd_ptr];
                    end else begin
                        o_Busy <= (count_next != '0);
                    end
                end
                LAUNCH: state <= WAIT_ACTIVE;
                WAIT_ACTIVE: begin
                    if (i_Tx_Active) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        state <= GAP;
                    end
                end
                // Done is two cycles long; wait for it to drop so one frame is never counted twice.
                GAP: begin
                    if (!i_Tx_Done) begin
                        state  <= IDLE;
                        o_Busy <= (count_next != '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
